// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, types and helpers for the 3x3 Sobel stage.
//   PIX_W / GRAD_W / MAG_W : pixel, signed gradient and magnitude widths
//   pix_t, grad_t, mag_t   : the matching typedefs
//   win_t                  : 3x3 window, indexed win[row][col], row 0 = top,
//                            col 0 = oldest column
//   SAT_LIMIT              : largest value pixel_o can carry
package sobel_pkg;

    localparam int PIX_W     = 8;
    localparam int GRAD_W    = 11;
    localparam int MAG_W     = 11;
    localparam int SAT_LIMIT = 255;

    typedef logic [PIX_W-1:0]         pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic [MAG_W-1:0]         mag_t;
    typedef pix_t [2:0][2:0]          win_t;

    // a + 2b + c, the 1-2-1 smoothing term shared by both kernels.
    // Pixels are unsigned, so the size casts zero-extend.
    function automatic grad_t tap_sum(pix_t a, pix_t b, pix_t c);
        return grad_t'(a) + (grad_t'(b) <<< 1) + grad_t'(c);
    endfunction

    // |g| never overflows: the gradient range is -1020..1020.
    function automatic mag_t abs_grad(grad_t g);
        return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
    endfunction

endpackage

// File: rtl/sobel_window_3x3_if.sv
// sobel_window_3x3_if: pixel stream into and out of the Sobel stage.
//   valid_i, row0_i (bottom/newest), row1_i (middle), row2_i (top)
//   pixel_o, edge_o, pixel_valid_o, frame_done_o
// Handshake: valid-only, no ready. A beat transfers on every rising clk edge
// where its valid is high; the receiver must always accept. pixel_o/edge_o/
// frame_done_o are meaningful only while pixel_valid_o is high.
interface sobel_window_3x3_if;
    import sobel_pkg::*;

    logic valid_i;
    pix_t row0_i;
    pix_t row1_i;
    pix_t row2_i;
    pix_t pixel_o;
    logic edge_o;
    logic pixel_valid_o;
    logic frame_done_o;

    modport master (
        output valid_i, row0_i, row1_i, row2_i,
        input  pixel_o, edge_o, pixel_valid_o, frame_done_o
    );

    modport slave (
        input  valid_i, row0_i, row1_i, row2_i,
        output pixel_o, edge_o, pixel_valid_o, frame_done_o
    );

endinterface

// File: rtl/sobel_gradient.sv
// sobel_gradient: E1/E2 datapath of the Sobel stage.
//   clk, rst          : clock, asynchronous active-low reset
//   win, win_valid,   : registered 3x3 window with its valid/last tag
//   win_last
//   pixel, edge_flag  : saturated |Gx|+|Gy| and pixel >= THRESHOLD
//   pix_valid,        : output qualifiers, two edges behind the window
//   pix_last
module sobel_gradient
    import sobel_pkg::*;
#(
    parameter int THRESHOLD = 100
) (
    input  logic clk,
    input  logic rst,
    input  win_t win,
    input  logic win_valid,
    input  logic win_last,
    output pix_t pixel,
    output logic edge_flag,
    output logic pix_valid,
    output logic pix_last
);

    localparam pix_t THR     = pix_t'(THRESHOLD);
    localparam mag_t SAT_MAG = mag_t'(SAT_LIMIT);

    grad_t gx_c;
    grad_t gy_c;
    grad_t gx_q;
    grad_t gy_q;
    logic  v1;
    logic  l1;
    mag_t  mag;
    pix_t  pix_sat;

    always_comb begin
        gx_c = tap_sum(win[0][2], win[1][2], win[2][2])
             - tap_sum(win[0][0], win[1][0], win[2][0]);
        gy_c = tap_sum(win[2][0], win[2][1], win[2][2])
             - tap_sum(win[0][0], win[0][1], win[0][2]);
    end

    // E1: gradients. Held when no window is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gx_q <= '0;
            gy_q <= '0;
            v1   <= 1'b0;
            l1   <= 1'b0;
        end else begin
            v1 <= win_valid;
            l1 <= win_valid & win_last;
            if (win_valid) begin
                gx_q <= gx_c;
                gy_q <= gy_c;
            end
        end
    end

    always_comb begin
        mag     = abs_grad(gx_q) + abs_grad(gy_q);
        pix_sat = (mag > SAT_MAG) ? pix_t'(SAT_LIMIT) : mag[PIX_W-1:0];
    end

    // E2: saturated magnitude and edge flag; data holds between outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel     <= '0;
            edge_flag <= 1'b0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
        end else begin
            pix_valid <= v1;
            pix_last  <= v1 & l1;
            if (v1) begin
                pixel     <= pix_sat;
                edge_flag <= (pix_sat >= THR);
            end
        end
    end

endmodule

// File: rtl/sobel_window_3x3.sv
// sobel_window_3x3: sliding 3x3 window over three aligned line-buffer taps,
// Sobel gradient magnitude and edge flag.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of sobel_window_3x3_if (taps in, pixel/edge out)
// The window shifts one column per accepted beat. Columns 0 and 1 of each row
// only prime the window, so every output window lies inside a single row.
module sobel_window_3x3
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int THRESHOLD  = 100
) (
    input logic               clk,
    input logic               rst,
    sobel_window_3x3_if.slave bus
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = (IMG_HEIGHT > 3) ? $clog2(IMG_HEIGHT - 2) : 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 3);
    localparam logic [CW-1:0] COL_FIRST_OUT = CW'(2);

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    win_t          win;
    logic          win_valid;
    logic          win_last;

    pix_t pixel;
    logic edge_flag;
    logic pix_valid;
    logic pix_last;

    // E0: window load plus the valid/last tag for the window it produces.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            win       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            win_valid <= bus.valid_i && (col_cnt >= COL_FIRST_OUT);
            win_last  <= bus.valid_i && (col_cnt == COL_LAST)
                                     && (row_cnt == ROW_LAST);
            if (bus.valid_i) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= bus.row2_i;
                win[1][2] <= bus.row1_i;
                win[2][2] <= bus.row0_i;

                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

    sobel_gradient #(
        .THRESHOLD (THRESHOLD)
    ) u_gradient (
        .clk       (clk),
        .rst       (rst),
        .win       (win),
        .win_valid (win_valid),
        .win_last  (win_last),
        .pixel     (pixel),
        .edge_flag (edge_flag),
        .pix_valid (pix_valid),
        .pix_last  (pix_last)
    );

    assign bus.pixel_o       = pixel;
    assign bus.edge_o        = edge_flag;
    assign bus.pixel_valid_o = pix_valid;
    assign bus.frame_done_o  = pix_last;

endmodule

// File: tb/tb_sobel_window_3x3.sv
// tb_sobel_window_3x3: randomized and directed stimulus for sobel_window_3x3
// with a frame-level Sobel reference model and a cycle-accurate scoreboard.
module tb_sobel_window_3x3;
    import sobel_pkg::*;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int THR = 100;
    localparam int EW  = 42;   // {due_cycle[31:0], last, edge, pixel[7:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sobel_window_3x3_if bus_if ();

    sobel_window_3x3 #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .THRESHOLD  (THR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // ---------------- scoreboard state ----------------
    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int m_col     = 0;
    int m_row     = 0;
    int obs_valid = 0;
    int obs_done  = 0;
    int col_pix[W][3];   // taps of the current row, [column][0=top..2=bottom]
    int img[H][W];
    logic [EW-1:0] exp_q[$];

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // Sees each accepted beat, keeps the row's columns, and when three
    // columns are present computes the Sobel result directly from the kernel
    // definitions. The result is due two cycles after the sampling edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst && bus_if.valid_i) begin
            col_pix[m_col][0] = int'(bus_if.row2_i);
            col_pix[m_col][1] = int'(bus_if.row1_i);
            col_pix[m_col][2] = int'(bus_if.row0_i);
            if (m_col >= 2) begin
                int gx, gy, mag, pix;
                logic lst, edg;
                logic [7:0] p8;
                int a, c;
                a   = m_col - 2;
                c   = m_col;
                gx  = (col_pix[c][0] + 2 * col_pix[c][1] + col_pix[c][2])
                    - (col_pix[a][0] + 2 * col_pix[a][1] + col_pix[a][2]);
                gy  = (col_pix[a][2] + 2 * col_pix[a + 1][2] + col_pix[c][2])
                    - (col_pix[a][0] + 2 * col_pix[a + 1][0] + col_pix[c][0]);
                mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                pix = (mag > 255) ? 255 : mag;
                p8  = 8'(pix);
                edg = (pix >= THR);
                lst = (m_row == H - 3) && (m_col == W - 1);
                exp_q.push_back({32'(cyc + 2), lst, edg, p8});
            end
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row == H - 3) ? 0 : m_row + 1;
            end
        end
    end

    // ---------------- output checker ----------------
    initial forever begin
        logic [EW-1:0] e;
        @(negedge clk);
        if (!rst) begin
            check_val("rst_pixel_valid", int'(bus_if.pixel_valid_o), 0);
            check_val("rst_pixel", int'(bus_if.pixel_o), 0);
            check_val("rst_edge", int'(bus_if.edge_o), 0);
            check_val("rst_frame_done", int'(bus_if.frame_done_o), 0);
        end else if (exp_q.size() > 0 && int'(exp_q[0][41:10]) == cyc) begin
            e = exp_q.pop_front();
            check_val("pixel_valid", int'(bus_if.pixel_valid_o), 1);
            check_val("pixel", int'(bus_if.pixel_o), int'(e[7:0]));
            check_val("edge", int'(bus_if.edge_o), int'(e[8]));
            check_val("frame_done", int'(bus_if.frame_done_o), int'(e[9]));
            obs_valid++;
            if (bus_if.frame_done_o) obs_done++;
        end else begin
            check_val("idle_pixel_valid", int'(bus_if.pixel_valid_o), 0);
            check_val("idle_frame_done", int'(bus_if.frame_done_o), 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input int t2, input int t1, input int t0);
        @(posedge clk);
        #1;
        bus_if.valid_i = v;
        bus_if.row2_i  = 8'(t2);
        bus_if.row1_i  = 8'(t1);
        bus_if.row0_i  = 8'(t0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, $urandom_range(0, 255), $urandom_range(0, 255),
                         $urandom_range(0, 255));
    endtask

    // t: 0 = top tap (row2_i) .. 2 = bottom tap (row0_i); r: output row index.
    function automatic int tap(input int mode, input int t, input int r, input int c);
        case (mode)
            0:       return 77;
            1:       return (c < 4) ? 0 : 255;
            2:       return (t == 2) ? 200 : 0;
            3:       return 10 * c;
            default: return img[r + t][c];
        endcase
    endfunction

    task automatic fill_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = $urandom_range(0, 255);
    endtask

    task automatic drive_beat(input int mode, input int r, input int c, input logic gaps);
        if (gaps) idle($urandom_range(0, 2));
        drive(1'b1, tap(mode, 0, r, c), tap(mode, 1, r, c), tap(mode, 2, r, c));
    endtask

    task automatic run_frame(input string tag, input int mode, input logic gaps);
        obs_valid = 0;
        obs_done  = 0;
        if (mode == 4) fill_img();
        for (int r = 0; r < H - 2; r++)
            for (int c = 0; c < W; c++)
                drive_beat(mode, r, c, gaps);
        idle(4);
        check_val({tag, "_outputs"}, obs_valid, 24);
        check_val({tag, "_frame_done"}, obs_done, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus_if.valid_i = 1'b0;
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus_if.valid_i = 1'b0;
        bus_if.row0_i  = '0;
        bus_if.row1_i  = '0;
        bus_if.row2_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        run_frame("uniform", 0, 1'b0);
        run_frame("vstep", 1, 1'b0);
        run_frame("hstep", 2, 1'b0);
        run_frame("ramp", 3, 1'b0);
        run_frame("rand_gaps_a", 4, 1'b1);
        run_frame("rand_gaps_b", 4, 1'b1);
        run_frame("rand_dense", 4, 1'b0);

        // valid_i 1,1,1,0,0,1 from column 0: outputs for columns 2 and 3 only,
        // separated by a two-cycle gap (cycle timing checked by the scoreboard).
        obs_valid = 0;
        drive_beat(3, 0, 0, 1'b0);
        drive_beat(3, 0, 1, 1'b0);
        drive_beat(3, 0, 2, 1'b0);
        idle(2);
        drive_beat(3, 0, 3, 1'b0);
        idle(4);
        check_val("gap_outputs", obs_valid, 2);

        // Reset at row 1, column 5 of a fresh frame.
        do_reset();
        fill_img();
        for (int c = 0; c < W; c++) drive_beat(4, 0, c, 1'b0);
        for (int c = 0; c <= 5; c++) drive_beat(4, 1, c, 1'b0);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus_if.valid_i = 1'b0;
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        #1;
        check_val("midrst_pixel_valid", int'(bus_if.pixel_valid_o), 0);
        check_val("midrst_pixel", int'(bus_if.pixel_o), 0);
        check_val("midrst_edge", int'(bus_if.edge_o), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        run_frame("post_reset", 4, 1'b0);

        idle(4);
        check_val("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sobel_window_3x3.md
# sobel_window_3x3

Consumes the three vertically aligned row taps from the double line buffer (current row, one row back, two rows back). It assembles a sliding 3x3 pixel window and computes the Sobel gradients Gx and Gy, then outputs a saturated 8-bit gradient magnitude with an edge flag. It is the stage directly downstream of the line buffer and feeds the output pixel writer.

## Interface
- IMG_WIDTH, default 640: pixels per row; must be at least 3.
- IMG_HEIGHT, default 480: rows per frame; must be at least 3.
- THRESHOLD, default 100: edge_o asserts when magnitude >= THRESHOLD. Range 0..255.
- clk  in  1  sole clock; all logic triggers on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  all three taps hold valid pixels of the same column this cycle.
- row0_i  in  8  bottom row, i.e. the newest/current row.
- row1_i  in  8  middle row, delayed one line.
- row2_i  in  8  top row, delayed two lines.
- pixel_o  out  8  saturated |Gx|+|Gy| for the window centre.
- edge_o  out  1  pixel_o >= THRESHOLD; qualified by pixel_valid_o.
- pixel_valid_o  out  1  pixel_o and edge_o are valid this cycle.
- frame_done_o  out  1  one-cycle pulse on the last output pixel of a frame.

## Operation
- Window: w[r][c], with r0 = row2_i (top), r2 = row0_i (bottom), c0 = oldest column, c2 = newest.
  - Shifts left only on valid_i; the new column enters c2.
  - Holds its contents when valid_i is low.
- col_cnt (0..IMG_WIDTH-1) increments on each valid_i and wraps to 0.
  - The wrap increments row_cnt (0..IMG_HEIGHT-3).
  - When row_cnt wraps, both counters are 0 and the next valid_i starts a new frame.
- Output generation: an accepted beat with pre-increment col_cnt >= 2 produces exactly one output.
  - col_cnt 0 and 1 produce nothing, so no window ever straddles two rows.
  - No border padding: each frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs.
- Gx = (w[0][2]+2w[1][2]+w[2][2]) - (w[0][0]+2w[1][0]+w[2][0]); signed 11-bit, range -1020..1020.
- Gy = (w[2][0]+2w[2][1]+w[2][2]) - (w[0][0]+2w[0][1]+w[0][2]); signed 11-bit.
- mag = |Gx|+|Gy|, unsigned 11-bit, range 0..2040. pixel_o = min(mag, 255).
- edge_o is evaluated on the saturated pixel_o value.
- frame_done_o asserts together with pixel_valid_o for the beat accepted at row_cnt = IMG_HEIGHT-3, col_cnt = IMG_WIDTH-1.
- No backpressure: the pipeline advances every cycle whether or not valid_i is high.

## Timing
- All outputs reset to 0 asynchronously when rst goes low.
  - Window, counters and pipeline valid bits also clear.
  - Release is synchronous to clk.
- Three register stages:
  - Edge E0 samples valid_i and loads the window plus a valid/last tag.
  - Edge E1 registers Gx, Gy, valid and last.
  - Edge E2 registers pixel_o, edge_o, pixel_valid_o and frame_done_o.
  - Latency: outputs are visible in the cycle after E2, i.e. 2 cycles after the sampling edge.
- Throughput is one pixel per cycle. valid_i gaps reproduce as pixel_valid_o gaps of equal length, 2 cycles later.
- Gaps may occur anywhere, including mid-row and at row boundaries, without affecting results.
- pixel_o and edge_o are don't-care when pixel_valid_o is low; implementations hold their last values.
- Reset mid-frame:
  - In-flight pixels are discarded and no frame_done_o is issued.
  - The first valid_i after release is treated as column 0 of row 0.

## Structure
- Package sobel_pkg holds:
  - PIX_W = 8, GRAD_W = 11, MAG_W = 11.
  - The pixel and gradient typedefs.
  - The saturation limit, 255.
- Sub-module sobel_gradient is purely the E1/E2 datapath: window in, pixel/edge out, with valid and last pass-through.
- The top level holds the window shift registers and the col/row counters.

## Test plan
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=6, THRESHOLD=100, valid_i held high, unless stated otherwise.
- Uniform frame, all taps = 77 -> 24 outputs, every pixel_o = 0 and edge_o = 0; one frame_done_o on the 24th output.
- Vertical step, columns 0-3 = 0 and columns 4-7 = 255 on all rows:
  - Each row gives 6 outputs, pattern 0,0,255,255,0,0.
  - edge_o is set on the 255 values.
  - Internal Gx = 1020 and Gy = 0 at the step.
- Horizontal step, row2_i = 0, row1_i = 0, row0_i = 200 -> every output has Gy = 800 and pixel_o = 255 (saturated).
- Latency and gaps: valid_i pattern 1,1,1,0,0,1 from column 0:
  - pixel_valid_o rises exactly 2 cycles after the third valid beat.
  - It then shows a 2-cycle gap before the next output.
- Ramp, pixel = 10*column on all rows -> Gx = 80, Gy = 0, pixel_o = 80 and edge_o = 0 for all outputs.
- Reset mid-row:
  - Assert rst low at row 1, column 5: all outputs drop to 0 immediately.
  - After release, a full frame produces 24 outputs and exactly one frame_done_o.
